stream_wr_sink: RTL

- DUT-side receiver for the host-to-DUT stream path of the emulation transactor.
- Per-port slices arrive on the write-port bus, each strobed by its active bit, and are assembled into one full DUT word.
- Completed words are buffered in a small first-word-fall-through FIFO and delivered to DUT logic over a valid/ready handshake.
- Slices for partial words are never lost; overflow and sequencing faults are reported as sticky flags.

---
 rtl/stream_wr_sink.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/stream_wr_sink.sv
// Host-to-DUT stream receiver: assembles per-port write slices into full words
// and buffers them in a first-word-fall-through FIFO. Optional STREAM_WR_SINK_STATS_EN adds pop/high-water stats.
module stream_wr_sink #(
  parameter int NUM_WR_PORT = 4,
  parameter int WPORT_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_l,
  input  logic [NUM_WR_PORT-1:0]               write_inst_active,
  input  logic [NUM_WR_PORT*WPORT_WIDTH-1:0]   write_port_data,
  input  logic                                 flush,
  output logic                                 out_valid,
  output logic [NUM_WR_PORT*WPORT_WIDTH-1:0]   out_data,
  input  logic                                 out_ready,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
  output logic                                 err_dup,
  output logic                                 err_ovf,
  output logic [7:0]                           ovf_count
`ifdef STREAM_WR_SINK_STATS_EN
  ,
  output logic [31:0]                          word_count,
  output logic [$clog2(FIFO_DEPTH):0]          max_level
`endif
);

  localparam int WORD_W = NUM_WR_PORT * WPORT_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  // Assembly state
  logic [NUM_WR_PORT-1:0] mask_q, mask_d;
  logic [WORD_W-1:0]      asm_q, asm_d;

  // FIFO state
  logic [WORD_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;

  // Error reporting
  logic                   err_dup_q, err_dup_d;
  logic                   err_ovf_q, err_ovf_d;
  logic [7:0]             ovf_cnt_q, ovf_cnt_d;

  fifo_state_e            fifo_state;
  logic [NUM_WR_PORT-1:0] strobe;
  logic [NUM_WR_PORT-1:0] mask_next;
  logic [WORD_W-1:0]      merged_word;
  logic                   word_done;
  logic                   dup_hit;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Strobes arriving together with flush are discarded outright.
  assign strobe    = flush ? '0 : write_inst_active;
  assign mask_next = mask_q | strobe;
  assign word_done = ~flush & (&mask_next);
  assign dup_hit   = |(mask_q & strobe);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    merged_word = asm_q;
    for (int i = 0; i < NUM_WR_PORT; i++) begin
      if (strobe[i]) begin
        merged_word[i*WPORT_WIDTH +: WPORT_WIDTH] = write_port_data[i*WPORT_WIDTH +: WPORT_WIDTH];
      end
    end
  end

  always_comb begin
    fifo_state = FIFO_PARTIAL;
    if (level_q == '0) begin
      fifo_state = FIFO_EMPTY;
    end else if (level_q == DEPTH_LVL) begin
      fifo_state = FIFO_FULL;
    end
  end

  assign out_valid = (fifo_state != FIFO_EMPTY);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts the word when the head leaves in the same cycle.
  assign push      = word_done & ((fifo_state != FIFO_FULL) | pop);
  assign drop      = word_done & ~push;

  always_comb begin
    mask_d    = word_done ? '0 : mask_next;
    asm_d     = merged_word;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    level_d   = level_q;
    err_dup_d = err_dup_q | dup_hit;
    err_ovf_d = err_ovf_q | drop;
    ovf_cnt_d = ovf_cnt_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    // Flush clears assembly and FIFO contents but keeps the sticky error record.
    if (flush) begin
      mask_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mask_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_dup_q <= 1'b0;
      err_ovf_q <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      mask_q    <= mask_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_dup_q <= err_dup_d;
      err_ovf_q <= err_ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // NOTE: data storage is deliberately not reset; mask and level qualify every slice and entry.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
    if (push) begin
      mem_q[wr_ptr_q] <= merged_word;
    end
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign err_dup    = err_dup_q;
  assign err_ovf    = err_ovf_q;
  assign ovf_count  = ovf_cnt_q;

`ifdef STREAM_WR_SINK_STATS_EN
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic [LVL_W-1:0] max_lvl_q, max_lvl_d;

  // The high-water mark tracks the next level so it never lags fifo_level.
  always_comb begin
    word_cnt_d = word_cnt_q + 32'(pop);
    max_lvl_d  = (level_d > max_lvl_q) ? level_d : max_lvl_q;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      word_cnt_q <= '0;
      max_lvl_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      max_lvl_q  <= max_lvl_d;
    end
  end

  assign word_count = word_cnt_q;
  assign max_level  = max_lvl_q;
`endif

endmodule
